// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line constants and receiver state encoding
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte handshake and status bundle
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ack;
    logic                      rx_busy;
    logic                      frame_err;
    logic                      overrun;

    // Receiver side: presents the byte and status, takes the acknowledge
    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous serial line
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values are simply the previous stage
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Reset to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive stage: 8N1 deserialiser with valid/ack output
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_receiver_if.master   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_state_e               state_q,     state_d;
    logic [CNT_W-1:0]          clk_cnt_q,   clk_cnt_d;
    logic [2:0]                bit_idx_q,   bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                      rx_valid_q,  rx_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q,   overrun_d;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame sequencing, mid-bit sampling and output handshake
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // An ack only means something while a byte is on offer
        if (rx_valid_q && bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_s == UART_START_LVL) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == UART_START_LVL) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Short low pulse: not a real start bit
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == UART_STOP_LVL) begin
                        state_d = IDLE;
                        if (!rx_valid_q || bus.rx_ack) begin
                            // Slot free, or freed by an ack this very cycle
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            // Old byte not taken: keep it, drop the new one
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            BREAK: begin
                // Wait out a held-low line so it cannot retrigger a frame
                if (rx_s == UART_STOP_LVL) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_busy   = (state_q != IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed vector bench for uart_receiver
module tb_uart_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int tests = 0;
    int fails = 0;

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLKS_PER_BIT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (u_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pre_ack;
        logic       ack_stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_ovr;
        int         exp_fe;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one 10-bit frame starting just after an edge; counts edges from that edge
    task automatic run_frame(input logic [7:0] b, input logic stop, input logic ack_stop,
                             output int rise, output int fe_n, output int ov_n);
        logic [9:0] fr;
        logic       pv;
        fr   = {stop, b, 1'b0};
        rise = -1;
        fe_n = 0;
        ov_n = 0;
        pv   = u_if.rx_valid;
        for (int k = 0; k < 160; k++) begin
            rx        = fr[k / 16];
            u_if.rx_ack = ack_stop && (k == 154);
            step();
            if (!pv && u_if.rx_valid && rise < 0) rise = k + 1;
            pv = u_if.rx_valid;
            if (u_if.frame_err) fe_n++;
            if (u_if.overrun) ov_n++;
        end
        u_if.rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        u_if.rx_ack = 1'b1;
        step();
        u_if.rx_ack = 1'b0;
    endtask

    initial begin
        int rise;
        int fe_n;
        int ov_n;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 0};
        vecs[1] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1, 0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 0, 1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 0, 0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 0, 0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 0, 0};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 0};

        u_if.rx_ack = 1'b0;
        repeat (3) step();
        check("reset rx_data",   {24'd0, u_if.rx_data}, 32'h0);
        check("reset rx_valid",  {31'd0, u_if.rx_valid}, 32'h0);
        check("reset rx_busy",   {31'd0, u_if.rx_busy}, 32'h0);
        check("reset frame_err", {31'd0, u_if.frame_err}, 32'h0);
        check("reset overrun",   {31'd0, u_if.overrun}, 32'h0);
        rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_ack) ack_pulse();
            run_frame(vecs[i].data, vecs[i].stop, vecs[i].ack_stop, rise, fe_n, ov_n);
            if (!vecs[i].stop) begin
                rx = 1'b0;
                repeat (40) step();
                if (u_if.frame_err) fe_n++;
                check($sformatf("v%0d busy in break", i), {31'd0, u_if.rx_busy}, 32'h1);
                rx = 1'b1;
                step();
                step();
                check($sformatf("v%0d busy before release", i), {31'd0, u_if.rx_busy}, 32'h1);
                step();
                check($sformatf("v%0d busy after release", i), {31'd0, u_if.rx_busy}, 32'h0);
            end
            if (i == 0) check("v0 rx_valid rise edge", rise, 32'd155);
            check($sformatf("v%0d rx_data", i),   {24'd0, u_if.rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d rx_valid", i),  {31'd0, u_if.rx_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d overrun", i),   ov_n, vecs[i].exp_ovr);
            check($sformatf("v%0d frame_err", i), fe_n, vecs[i].exp_fe);
            check($sformatf("v%0d rx_busy", i),   {31'd0, u_if.rx_busy}, 32'h0);
        end

        // Glitch: five low cycles must be rejected at the mid-start sample
        ack_pulse();
        fe_n = 0;
        for (int k = 0; k < 20; k++) begin
            rx = (k < 5) ? 1'b0 : 1'b1;
            step();
            if (u_if.frame_err) fe_n++;
            if (k + 1 == 10) check("glitch busy at edge 10", {31'd0, u_if.rx_busy}, 32'h1);
            if (k + 1 == 11) check("glitch idle at edge 11", {31'd0, u_if.rx_busy}, 32'h0);
        end
        check("glitch rx_valid",  {31'd0, u_if.rx_valid}, 32'h0);
        check("glitch frame_err", fe_n, 32'd0);

        // Reset in the middle of a 0xFF frame, then a clean 0x5A frame
        run_frame(8'h77, 1'b1, 1'b0, rise, fe_n, ov_n);
        check("pre-reset rx_valid", {31'd0, u_if.rx_valid}, 32'h1);
        rx = 1'b0;
        repeat (16) step();
        rx = 1'b1;
        repeat (40) step();
        check("mid-frame busy", {31'd0, u_if.rx_busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst rx_valid", {31'd0, u_if.rx_valid}, 32'h0);
        check("async rst rx_data",  {24'd0, u_if.rx_data}, 32'h0);
        check("async rst rx_busy",  {31'd0, u_if.rx_busy}, 32'h0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        run_frame(8'h5A, 1'b1, 1'b0, rise, fe_n, ov_n);
        check("post-reset rise edge", rise, 32'd155);
        check("post-reset rx_data",   {24'd0, u_if.rx_data}, 32'h5A);
        check("post-reset frame_err", fe_n, 32'd0);
        check("post-reset overrun",   ov_n, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
